branch_flush_ctrl: RTL
======================

# branch_flush_ctrl

Control-flow sequencer between the ID-stage branch predictor and the IF/ID, ID/EX pipeline registers. Tracks the single in-flight predicted branch from ID into EX and holds its recovery PC. Resolves it against the EX comparison and arbitrates PC redirects, stalls and flushes among mispredict recovery, load-use hazards and predicted-taken redirects. Emits a one-cycle training pulse to the 2-bit predictor.

## Interface
Parameters:
- XLEN, 32, address width
- CTR_W, 16, statistics counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-low
- id_branch_i  in  1  ID holds a conditional branch
- id_predict_i  in  1  predictor verdict for the ID branch (1 = taken)
- id_pc_i  in  XLEN  PC of the ID instruction
- id_target_i  in  XLEN  id_pc_i + imm, computed in ID
- load_use_i  in  1  hazard unit: ID instruction depends on a load in EX
- ex_equal_i  in  1  EX operand comparison; meaningful only in PENDING
- pc_sel_o  out  2  0 = pc+4, 1 = id_target_i, 2 = recovery PC, 3 unused
- redirect_pc_o  out  XLEN  recovery PC register
- stall_pc_o, stall_if_id_o  out  1  hold PC / IF/ID
- flush_if_id_o, flush_id_ex_o  out  1  bubble into IF/ID / ID/EX
- update_o, update_taken_o  out  1  predictor training strobe and outcome
- branch_cnt_o, mispredict_cnt_o  out  CTR_W  statistics

## Operation
- States: IDLE (no branch in EX) and PENDING (captured branch now in EX).
- accept = id_branch_i & ~load_use_i & ~mispredict. On accept:
  - capture pred_q = id_predict_i.
  - capture redirect_pc_o = id_predict_i ? id_pc_i+4 : id_target_i.
  - Next state is PENDING.
- Otherwise the next state is IDLE.
- In PENDING:
  - mispredict = pred_q ^ ex_equal_i.
  - update_o = 1 and update_taken_o = ex_equal_i, every PENDING cycle.
- Output priority, highest first:
  1. mispredict: pc_sel = 2, flush_if_id = flush_id_ex = 1, no stall. The branch in ID is squashed and not captured.
  2. load_use: stall_pc = stall_if_id = 1, flush_id_ex = 1, pc_sel = 0, nothing captured. Applies whether or not ID holds a branch.
  3. accept with id_predict_i = 1: pc_sel = 1, flush_if_id = 1.
  4. Otherwise all controls 0 and pc_sel = 0.
- Back-to-back branches: a correct resolution in PENDING combined with accept keeps the state PENDING and overwrites the captured values.
- Arithmetic is modulo 2^XLEN. pc+4 wrap at 0xFFFFFFFC gives 0x0.

## Timing
- All outputs are combinational from the state registers and inputs, with zero-cycle latency. State, pred_q and redirect_pc_o update on the rising edge.
- Mispredict penalty is 2 cycles: flush IF/ID and ID/EX, with the redirect in the resolving cycle.
- Predicted-taken penalty is 1 cycle.
- Branch resolution occurs exactly 1 cycle after accept.
- While rst_i = 0 at an edge:
  - state ← IDLE, pred_q ← 0, redirect_pc_o ← 0, counters ← 0.
  - All combinational outputs are forced to 0 while rst_i is low.
- Reset mid-PENDING discards the branch with no update_o.

## Configuration
- BRANCH_STATS_EN defined:
  - branch_cnt_o counts update_o cycles.
  - mispredict_cnt_o counts mispredict cycles.
  - Both saturate at 2^CTR_W-1 and clear on reset.
- Undefined: both ports are tied to 0, no counter flops are built, and the ports remain present.

## Structure
- Package branch_ctrl_pkg holds:
  - the state enum, IDLE = 1'b0 and PENDING = 1'b1;
  - pc_sel encodings PCSEL_SEQ = 0, PCSEL_PRED = 1, PCSEL_RECOVER = 2.
- Sub-module sat_counter (parameter W; inc, clr, count) is instantiated twice under BRANCH_STATS_EN.

## Test plan
- Predict taken, resolve taken:
  - Stimulus: id_branch = 1, id_predict = 1, id_pc = 0x100, id_target = 0x140; next cycle ex_equal = 1.
  - Cycle 0: pc_sel = 1, flush_if_id = 1.
  - Cycle 1: update = 1, update_taken = 1, no flush.
- Predict taken, resolve not-taken (same stimulus, ex_equal = 0 in cycle 1): pc_sel = 2, redirect_pc = 0x104, both flushes = 1, mispredict_cnt = 1.
- Predict not-taken, resolve taken (id_pc = 0x200, id_target = 0x1C0): cycle 0 pc_sel = 0; cycle 1 pc_sel = 2, redirect_pc = 0x1C0.
- Load-use on a branch:
  - Stimulus: load_use = 1 with id_branch = 1 for one cycle, then 0.
  - Cycle 0: stall_pc = stall_if_id = 1, flush_id_ex = 1, state stays IDLE.
  - Cycle 1: the branch is accepted.
- Mispredict with a new branch in ID: PENDING, pred_q = 1, ex_equal = 0, id_branch = 1 → branch not captured and next state IDLE.
- Wrap and reset:
  - id_pc = 0xFFFFFFFC, predict taken → redirect_pc = 0x0.
  - rst_i = 0 during PENDING → next cycle IDLE, update_o = 0, counters = 0.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// branch_ctrl_pkg
//    Shared definitions for the branch flush controller: the sequencer
//    state encoding and the pc_sel mux encodings driven towards the fetch
//    stage PC mux.
// ---------------------------------------------------------------------------
package branch_ctrl_pkg;

   // IDLE: no predicted branch in EX; PENDING: captured branch is in EX
   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_t;

   // Next-PC mux select encodings (value 3 is unused)
   localparam logic [1:0] PCSEL_SEQ     = 2'd0;
   localparam logic [1:0] PCSEL_PRED    = 2'd1;
   localparam logic [1:0] PCSEL_RECOVER = 2'd2;

endpackage

// File: rtl/branch_flush_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//    Saturating up-counter used for branch statistics.
//    Ports:
//       clk   - clock, rising edge
//       clr   - synchronous clear, wins over inc
//       inc   - increment request for this cycle
//       count - current count, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count up on inc, hold once the all-ones value is reached
   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/branch_flush_ctrl.sv
// ---------------------------------------------------------------------------
// branch_flush_ctrl
//    Control-flow sequencer sitting between the ID-stage branch predictor
//    and the IF/ID, ID/EX pipeline registers. Tracks the single in-flight
//    predicted branch from ID into EX, keeps its recovery PC, resolves it
//    against the EX comparison and arbitrates redirects, stalls and flushes.
//
//    Optional feature macro: BRANCH_STATS_EN builds the two saturating
//    statistics counters; without it the counter ports are tied to zero.
//
//    Ports:
//       clk_i            - clock, rising edge
//       rst_i            - synchronous active-low reset
//       id_branch_i      - ID holds a conditional branch
//       id_predict_i     - predictor verdict for the ID branch (1 = taken)
//       id_pc_i          - PC of the ID instruction
//       id_target_i      - branch target computed in ID
//       load_use_i       - load-use hazard on the ID instruction
//       ex_equal_i       - EX comparison result for the pending branch
//       pc_sel_o         - next-PC select (seq / predicted / recovery)
//       redirect_pc_o    - recovery PC of the pending branch
//       stall_pc_o       - hold the PC
//       stall_if_id_o    - hold IF/ID
//       flush_if_id_o    - bubble into IF/ID
//       flush_id_ex_o    - bubble into ID/EX
//       update_o         - predictor training strobe
//       update_taken_o   - actual outcome for training
//       branch_cnt_o     - resolved branch count
//       mispredict_cnt_o - mispredict count
// ---------------------------------------------------------------------------
module branch_flush_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CTR_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_branch_i,
   input  logic             id_predict_i,
   input  logic [XLEN-1:0]  id_pc_i,
   input  logic [XLEN-1:0]  id_target_i,
   input  logic             load_use_i,
   input  logic             ex_equal_i,
   output logic [1:0]       pc_sel_o,
   output logic [XLEN-1:0]  redirect_pc_o,
   output logic             stall_pc_o,
   output logic             stall_if_id_o,
   output logic             flush_if_id_o,
   output logic             flush_id_ex_o,
   output logic             update_o,
   output logic             update_taken_o,
   output logic [CTR_W-1:0] branch_cnt_o,
   output logic [CTR_W-1:0] mispredict_cnt_o
);

   state_t state_q;
   state_t next_state;
   logic   pred_q;
   logic   pending;
   logic   mispredict;
   logic   accept;

   // A mispredict squashes whatever sits in ID, so a branch there can only
   // be captured when the pending one resolved correctly (or none exists)
   assign pending    = (state_q == PENDING);
   assign mispredict = pending & (pred_q ^ ex_equal_i);
   assign accept     = id_branch_i & ~load_use_i & ~mispredict;

   // State, predicted direction and recovery PC registers. The recovery PC
   // is the path not taken by the prediction: fall-through when predicted
   // taken, the target when predicted not-taken.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q       <= IDLE;
         pred_q        <= 1'b0;
         redirect_pc_o <= '0;
      end else begin
         state_q <= next_state;
         if (accept) begin
            pred_q        <= id_predict_i;
            redirect_pc_o <= id_predict_i ? (id_pc_i + XLEN'(4)) : id_target_i;
         end
      end
   end

   // Next-state and prioritised control outputs: mispredict recovery first,
   // then load-use stall, then the predicted-taken redirect. Every control
   // is held low while reset is asserted.
   always_comb begin
      next_state     = IDLE;
      pc_sel_o       = PCSEL_SEQ;
      stall_pc_o     = 1'b0;
      stall_if_id_o  = 1'b0;
      flush_if_id_o  = 1'b0;
      flush_id_ex_o  = 1'b0;
      update_o       = 1'b0;
      update_taken_o = 1'b0;
      if (rst_i) begin
         if (pending) begin
            update_o       = 1'b1;
            update_taken_o = ex_equal_i;
         end
         if (mispredict) begin
            pc_sel_o      = PCSEL_RECOVER;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
         end else if (load_use_i) begin
            stall_pc_o    = 1'b1;
            stall_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
         end else if (accept && id_predict_i) begin
            pc_sel_o      = PCSEL_PRED;
            flush_if_id_o = 1'b1;
         end
         if (accept) begin
            next_state = PENDING;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   // Resolved-branch and mispredict statistics, cleared by reset
   sat_counter #(.W(CTR_W)) u_branch_cnt (
      .clk   (clk_i),
      .clr   (~rst_i),
      .inc   (update_o),
      .count (branch_cnt_o)
   );

   sat_counter #(.W(CTR_W)) u_mispredict_cnt (
      .clk   (clk_i),
      .clr   (~rst_i),
      .inc   (mispredict & rst_i),
      .count (mispredict_cnt_o)
   );
`else
   assign branch_cnt_o     = '0;
   assign mispredict_cnt_o = '0;
`endif

endmodule
